// File: rtl/xor_stream_cipher.sv
// XOR stream cipher (static key or per-packet Galois-LFSR keystream); 1-cycle registered output.
// Backpressure: s_ready follows the output register (~m_valid | m_ready) and drops during seed_load.
module xor_stream_cipher #(
  parameter int                 DATA_W       = 8,
  parameter int                 LFSR_W       = 32,
  parameter logic [LFSR_W-1:0]  TAPS         = 32'h8020_0003,
  parameter logic [LFSR_W-1:0]  DEFAULT_SEED = 32'hACE1_2468,
  parameter int                 CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] key,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

  if (DATA_W < 1 || DATA_W > LFSR_W) begin : g_bad_width
    $error("xor_stream_cipher: DATA_W must be within 1..LFSR_W");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("xor_stream_cipher: DEFAULT_SEED must be nonzero");
  end

  logic [LFSR_W-1:0] seed_reg;
  logic [LFSR_W-1:0] lfsr;
  logic              mode_q;
  logic              accept;
  logic              pkt_mode;
  logic [DATA_W-1:0] ks;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] seed_nz;

  // One keystream word consumes DATA_W Galois steps, unrolled within the cycle.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] r;
    r = v;
    for (int i = 0; i < DATA_W; i++) begin
      r = (r >> 1) ^ (r[0] ? TAPS : '0);
    end
    return r;
  endfunction

  assign s_ready   = (~m_valid | m_ready) & ~seed_load;
  assign accept    = s_valid & s_ready;
  assign pkt_mode  = busy ? mode_q : mode;
  assign ks        = pkt_mode ? lfsr[DATA_W-1:0] : key;
  assign lfsr_next = lfsr_advance(lfsr);
  assign seed_nz   = (seed == '0) ? DEFAULT_SEED : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_reg  <= DEFAULT_SEED;
      lfsr      <= DEFAULT_SEED;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      pkt_count <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      // seed_load and accept are mutually exclusive because s_ready is low during a load.
      if (seed_load) begin
        seed_reg <= seed_nz;
        lfsr     <= seed_nz;
      end else if (accept) begin
        if (s_last) begin
          lfsr <= seed_reg;
        end else if (pkt_mode) begin
          lfsr <= lfsr_next;
        end
      end

      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data ^ ks;
        m_last  <= s_last;
        busy    <= ~s_last;
        if (!busy) begin
          mode_q <= mode;
        end
        if (s_last) begin
          pkt_count <= pkt_count + CNT_W'(1);
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Scoreboard bench for xor_stream_cipher: driver pushes expected beats, monitor pops on m_valid & m_ready.
module tb_xor_stream_cipher;
  localparam int          DW   = 8;
  localparam int          LW   = 32;
  localparam int          CW   = 4;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] DEF  = 32'hACE1_2468;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] key = '0;
  logic          seed_load = 1'b0;
  logic [LW-1:0] seed = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] pkt_count;

  xor_stream_cipher #(.DATA_W(DW), .LFSR_W(LW), .TAPS(TAPS), .DEFAULT_SEED(DEF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .key(key), .seed_load(seed_load), .seed(seed),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         sb_q[$];
  logic [DW-1:0] cap_q[$];
  logic          capl_q[$];
  longint        acc_t[$];
  int            checks = 0;
  int            failures = 0;
  int            rdy_sel = 1;   // 0: hold low, 1: hold high, 2: random

  // Reference model: keystream word k of a packet is the low byte of the seed after k*DW shifts.
  logic [31:0] mdl_seed, mdl_base;
  int          mdl_k;
  logic        mdl_busy, mdl_mode;
  int          mdl_cnt;

  function automatic logic [31:0] ks_at(input logic [31:0] base, input int k);
    logic [31:0] s;
    s = base;
    for (int i = 0; i < k * DW; i++) s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] cap_at(input int i);
    return (i < cap_q.size()) ? cap_q[i] : 'x;
  endfunction

  task automatic model_reset();
    mdl_seed = DEF; mdl_base = DEF; mdl_k = 0;
    mdl_busy = 1'b0; mdl_mode = 1'b0; mdl_cnt = 0;
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic l, input logic md, input logic [DW-1:0] k);
    logic        pm;
    logic [31:0] st;
    beat_t       b;
    pm  = mdl_busy ? mdl_mode : md;
    st  = ks_at(mdl_base, mdl_k);
    b.d = d ^ (pm ? st[DW-1:0] : k);
    b.l = l;
    sb_q.push_back(b);
    if (!mdl_busy) mdl_mode = md;
    if (l) begin
      mdl_base = mdl_seed; mdl_k = 0; mdl_busy = 1'b0; mdl_cnt++;
    end else begin
      if (pm) mdl_k++;
      mdl_busy = 1'b1;
    end
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic md, input logic [DW-1:0] k);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l; mode = md; key = k;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      if (ok) break;
    end
    if (ok) begin
      model_accept(d, l, md, k);
      acc_t.push_back($time);
    end else begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic do_seed(input logic [31:0] v);
    seed_load = 1'b1; seed = v;
    @(negedge clk);
    chk("seed_load_blocks_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    mdl_seed = (v == 0) ? DEF : v; mdl_base = mdl_seed; mdl_k = 0;
    #1;
    seed_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; seed_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      if (sb_q.size() == 0 && !m_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending_beats", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic clear_cap();
    cap_q.delete(); capl_q.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_ready = (rdy_sel == 2) ? ($urandom_range(0, 3) != 0) : (rdy_sel == 1);
    end
  end

  // Monitor: a beat transfers at the next posedge when m_valid & m_ready are seen here.
  logic          prev_vld = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  beat_t         exp_b;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_vld && !prev_rdy) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data_last", {23'd0, m_last, m_data}, {23'd0, prev_last, prev_data});
        end
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_data);
          end else begin
            exp_b = sb_q.pop_front();
            chk("out_data", 32'(m_data), 32'(exp_b.d));
            chk("out_last", 32'(m_last), 32'(exp_b.l));
          end
          cap_q.push_back(m_data);
          capl_q.push_back(m_last);
        end
        prev_vld = m_valid; prev_rdy = m_ready; prev_data = m_data; prev_last = m_last;
      end else begin
        prev_vld = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] ct[16];
  int            len;

  initial begin
    model_reset();
    do_reset();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Static key, single-beat packet.
    clear_cap();
    send_beat(8'h3C, 1'b1, 1'b0, 8'hA5);
    chk("static_busy", 32'(busy), 32'd0);
    chk("static_pkt_count", 32'(pkt_count), 32'd1);
    wait_drain();
    chk("static_data", 32'(cap_at(0)), 32'h99);
    chk("static_last", 32'(capl_q.size() > 0 ? capl_q[0] : 1'bx), 32'd1);

    // Keystream from reset seed, restarted for each packet.
    do_reset();
    clear_cap();
    repeat (2) for (int i = 0; i < 3; i++) send_beat(8'h00, i == 2, 1'b1, 8'($urandom));
    wait_drain();
    chk("ks_first_byte", 32'(cap_at(0)), 32'h68);
    for (int i = 0; i < 3; i++) chk("ks_restart", 32'(cap_at(i + 3)), 32'(cap_at(i)));
    chk("ks_pkt_count", 32'(pkt_count), 32'd2);

    // Round trip with an explicit seed.
    do_seed(32'h1234_5678);
    clear_cap();
    for (int i = 0; i < 16; i++) send_beat(8'(i), i == 15, 1'b1, 8'($urandom));
    wait_drain();
    for (int i = 0; i < 16; i++) ct[i] = cap_at(i);
    do_seed(32'h1234_5678);
    clear_cap();
    for (int i = 0; i < 16; i++) send_beat(ct[i], i == 15, 1'b1, 8'($urandom));
    wait_drain();
    for (int i = 0; i < 16; i++) chk("roundtrip", 32'(cap_at(i)), i);

    // Zero seed substitutes the default seed.
    do_seed(32'h0);
    clear_cap();
    for (int i = 0; i < 3; i++) send_beat(8'h00, i == 2, 1'b1, 8'h00);
    do_seed(DEF);
    for (int i = 0; i < 3; i++) send_beat(8'h00, i == 2, 1'b1, 8'h00);
    wait_drain();
    chk("zero_seed_first", 32'(cap_at(0)), 32'h68);
    for (int i = 0; i < 3; i++) chk("zero_seed_equiv", 32'(cap_at(i)), 32'(cap_at(i + 3)));

    // Backpressure mid-stream.
    fork
      for (int i = 0; i < 8; i++) send_beat(8'($urandom), i == 7, 1'($urandom), 8'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_sel = 0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_m_valid", 32'(m_valid), 32'd1);
          chk("bp_s_ready", 32'(s_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rdy_sel = 1;
      end
    join
    wait_drain();
    acc_t.delete();
    for (int i = 0; i < 8; i++) send_beat(8'($urandom), i == 7, 1'b1, 8'($urandom));
    chk("throughput_span", 32'(acc_t[7] - acc_t[0]), 32'd70);
    wait_drain();

    // Reset mid-packet.
    do_reset();
    send_beat(8'h11, 1'b0, 1'b1, 8'h00);
    send_beat(8'h22, 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    chk("midpkt_busy", 32'(busy), 32'd1);
    do_reset();
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
    clear_cap();
    send_beat(8'h00, 1'b1, 1'b1, 8'h00);
    wait_drain();
    chk("midrst_first_ks", 32'(cap_at(0)), 32'h68);

    // Counter wrap and mid-packet mode toggle.
    do_reset();
    for (int p = 1; p <= 17; p++) begin
      send_beat(8'($urandom), 1'b1, 1'($urandom), 8'($urandom));
      if (p == 15) chk("cnt_15", 32'(pkt_count), 32'hF);
      if (p == 16) chk("cnt_16", 32'(pkt_count), 32'h0);
      if (p == 17) chk("cnt_17", 32'(pkt_count), 32'h1);
    end
    wait_drain();
    clear_cap();
    send_beat(8'h00, 1'b0, 1'b1, 8'h5A);
    send_beat(8'h00, 1'b0, 1'b0, 8'h5A);
    send_beat(8'h00, 1'b1, 1'b0, 8'h5A);
    for (int i = 0; i < 3; i++) send_beat(8'h00, i == 2, 1'b1, 8'h5A);
    wait_drain();
    for (int i = 0; i < 3; i++) chk("mode_toggle", 32'(cap_at(i)), 32'(cap_at(i + 3)));

    // Randomised traffic with random backpressure and seed loads.
    rdy_sel = 2;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) do_seed(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
        send_beat(8'($urandom), i == len - 1, 1'($urandom), 8'($urandom));
        chk("rand_busy", 32'(busy), 32'(mdl_busy));
        chk("rand_pkt_count", 32'(pkt_count), 32'(mdl_cnt % 16));
      end
    end
    rdy_sel = 1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
